// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Two-requester byte arbiter in front of a single UART transmitter.
//   Requester A (CPU console) and requester B (debug monitor) each push bytes
//   into a private FIFO. A three-state FSM hands one byte at a time to the
//   transmitter. With LINE_LOCK=1 the current owner keeps the line until it
//   sends a line feed (8'h0A) or runs dry. With LINE_LOCK=0 ownership is
//   re-arbitrated after every byte. Arbitration between two waiting
//   requesters is round-robin.
//
// Parameters
//   DEPTH      per-requester FIFO depth in bytes (power of two, 2..16)
//   LINE_LOCK  1: hold grant until owner sends 8'h0A, 0: arbitrate per byte
//
// Ports
//   CLK        clock, all state on its rising edge
//   RST_X      asynchronous active-low reset
//   A_WE       push strobe, requester A
//   A_DATA     push byte, requester A
//   A_FULL     FIFO A holds DEPTH bytes
//   B_WE       push strobe, requester B
//   B_DATA     push byte, requester B
//   B_FULL     FIFO B holds DEPTH bytes
//   TX_DATA    byte presented to the transmitter, held until the next issue
//   TX_WE      one-cycle transmit strobe
//   TX_READY   transmitter idle
//   OWNER      requester of the last issued byte (0=A, 1=B)
//   OVF_A      sticky: a push to FIFO A was dropped
//   OVF_B      sticky: a push to FIFO B was dropped
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int DEPTH     = 4,
  parameter bit LINE_LOCK = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       A_WE,
  input  logic [7:0] A_DATA,
  output logic       A_FULL,
  input  logic       B_WE,
  input  logic [7:0] B_DATA,
  output logic       B_FULL,
  output logic [7:0] TX_DATA,
  output logic       TX_WE,
  input  logic       TX_READY,
  output logic       OWNER,
  output logic       OVF_A,
  output logic       OVF_B
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    LF       = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------- FIFO A ----------------
  logic [7:0]    r_a_mem [DEPTH];
  logic [PW-1:0] r_a_wp;
  logic [PW-1:0] r_a_rp;
  logic [CW-1:0] r_a_cnt;
  logic          r_ovf_a;
  logic          w_a_push;
  logic          w_a_pop;
  logic          w_a_ne;
  logic [7:0]    w_a_head;

  // ---------------- FIFO B ----------------
  logic [7:0]    r_b_mem [DEPTH];
  logic [PW-1:0] r_b_wp;
  logic [PW-1:0] r_b_rp;
  logic [CW-1:0] r_b_cnt;
  logic          r_ovf_b;
  logic          w_b_push;
  logic          w_b_pop;
  logic          w_b_ne;
  logic [7:0]    w_b_head;

  // ---------------- arbiter ----------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio;       // 0: A wins a tie, 1: B wins a tie
  logic          w_prio_nxt;
  logic          r_owner;
  logic          r_tx_we;
  logic [7:0]    r_tx_data;
  logic          w_issue;
  logic          w_sel;
  logic          w_own_ne;

  // A push against a full FIFO is dropped even when the same FIFO is popped
  // in that cycle, so acceptance looks only at the registered count.
  assign A_FULL   = (r_a_cnt == FULL_CNT);
  assign B_FULL   = (r_b_cnt == FULL_CNT);
  assign w_a_push = A_WE && !A_FULL;
  assign w_b_push = B_WE && !B_FULL;
  assign w_a_ne   = (r_a_cnt != '0);
  assign w_b_ne   = (r_b_cnt != '0);
  assign w_a_head = r_a_mem[r_a_rp];
  assign w_b_head = r_b_mem[r_b_rp];
  assign w_a_pop  = w_issue && !w_sel;
  assign w_b_pop  = w_issue &&  w_sel;
  assign w_own_ne = r_owner ? w_b_ne : w_a_ne;

  // Storage arrays carry data only and are never reset; the pointers and
  // counts below decide what is valid.
  always_ff @(posedge CLK) begin
    if (w_a_push) r_a_mem[r_a_wp] <= A_DATA;
  end

  always_ff @(posedge CLK) begin
    if (w_b_push) r_b_mem[r_b_wp] <= B_DATA;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_a_wp  <= '0;
      r_a_rp  <= '0;
      r_a_cnt <= '0;
      r_ovf_a <= 1'b0;
    end else begin
      if (w_a_push) r_a_wp <= r_a_wp + 1'b1;
      if (w_a_pop)  r_a_rp <= r_a_rp + 1'b1;
      case ({w_a_push, w_a_pop})
        2'b10:   r_a_cnt <= r_a_cnt + 1'b1;
        2'b01:   r_a_cnt <= r_a_cnt - 1'b1;
        default: r_a_cnt <= r_a_cnt;
      endcase
      if (A_WE && A_FULL) r_ovf_a <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_b_cnt <= '0;
      r_ovf_b <= 1'b0;
    end else begin
      if (w_b_push) r_b_wp <= r_b_wp + 1'b1;
      if (w_b_pop)  r_b_rp <= r_b_rp + 1'b1;
      case ({w_b_push, w_b_pop})
        2'b10:   r_b_cnt <= r_b_cnt + 1'b1;
        2'b01:   r_b_cnt <= r_b_cnt - 1'b1;
        default: r_b_cnt <= r_b_cnt;
      endcase
      if (B_WE && B_FULL) r_ovf_b <= 1'b1;
    end
  end

  // Next-state and issue decision. GUARD exists because TX_READY is still
  // high in the cycle right after the strobe; WAIT only trusts READY after
  // the transmitter has had a chance to drop it.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_issue     = 1'b0;
    w_sel       = 1'b0;
    case (r_state)
      IDLE: begin
        if (TX_READY && (w_a_ne || w_b_ne)) begin
          w_issue     = 1'b1;
          w_sel       = (w_a_ne && w_b_ne) ? r_prio : w_b_ne;
          w_state_nxt = GUARD;
        end
      end
      GUARD: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (TX_READY) begin
          // TX_DATA still holds the last issued byte, so it doubles as the
          // end-of-line detector for the lock.
          if (LINE_LOCK && (r_tx_data != LF) && w_own_ne) begin
            w_issue     = 1'b1;
            w_sel       = r_owner;
            w_state_nxt = GUARD;
          end else begin
            w_prio_nxt  = ~r_owner;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_tx_we   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_tx_we <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_sel ? w_b_head : w_a_head;
        r_owner   <= w_sel;
      end
    end
  end

  assign TX_WE   = r_tx_we;
  assign TX_DATA = r_tx_data;
  assign OWNER   = r_owner;
  assign OVF_A   = r_ovf_a;
  assign OVF_B   = r_ovf_b;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//   Two arbiters (LINE_LOCK=1 and LINE_LOCK=0) share push stimulus; each has
//   its own transmitter model. A queue-based reference model predicts every
//   issued byte, its owner and timing, and the FULL/OVF flags.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;
  localparam int DEPTH = 4;

  logic       CLK   = 1'b0;
  logic       RST_X = 1'b0;
  logic       a_we  = 1'b0;
  logic       b_we  = 1'b0;
  logic [7:0] a_d   = 8'h00;
  logic [7:0] b_d   = 8'h00;
  logic [1:0] rdy   = 2'b11;
  bit         hold_low = 1'b0;

  logic [1:0] tx_we, a_full, b_full, owner, ovf_a, ovf_b;
  logic [7:0] tx_data [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state, index 0 = locked instance, 1 = per-byte instance
  logic [7:0] mq [4][$];        // [2*inst + requester]
  int         phase [2];        // 0 free, 1 strobe just issued, 2 awaiting ready
  bit         prio  [2];
  bit         mown  [2];
  logic [7:0] mlast [2];
  bit         movfa [2];
  bit         movfb [2];

  logic [7:0] lg  [2][$];
  bit         lgo [2][$];
  int         lgc [2][$];

  logic       c_rst, c_awe, c_bwe;
  logic [7:0] c_ad, c_bd;
  logic [1:0] c_rdy;

  always #5 CLK = ~CLK;

  uart_tx_arb #(.DEPTH(DEPTH), .LINE_LOCK(1'b1)) u_lock (
    .CLK(CLK), .RST_X(RST_X),
    .A_WE(a_we), .A_DATA(a_d), .A_FULL(a_full[0]),
    .B_WE(b_we), .B_DATA(b_d), .B_FULL(b_full[0]),
    .TX_DATA(tx_data[0]), .TX_WE(tx_we[0]), .TX_READY(rdy[0]),
    .OWNER(owner[0]), .OVF_A(ovf_a[0]), .OVF_B(ovf_b[0])
  );

  uart_tx_arb #(.DEPTH(DEPTH), .LINE_LOCK(1'b0)) u_free (
    .CLK(CLK), .RST_X(RST_X),
    .A_WE(a_we), .A_DATA(a_d), .A_FULL(a_full[1]),
    .B_WE(b_we), .B_DATA(b_d), .B_FULL(b_full[1]),
    .TX_DATA(tx_data[1]), .TX_WE(tx_we[1]), .TX_READY(rdy[1]),
    .OWNER(owner[1]), .OVF_A(ovf_a[1]), .OVF_B(ovf_b[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge of the reference model for instance i.
  task automatic step(input int i);
    int         na, nb, on;
    bit         ew, sel;
    logic [7:0] b;
    na  = mq[2*i].size();
    nb  = mq[2*i+1].size();
    ew  = 1'b0;
    sel = 1'b0;
    if (!c_rst) begin
      mq[2*i].delete();
      mq[2*i+1].delete();
      phase[i] = 0; prio[i] = 1'b0; mown[i] = 1'b0; mlast[i] = 8'h00;
      movfa[i] = 1'b0; movfb[i] = 1'b0;
    end else begin
      if (phase[i] == 0) begin
        if (c_rdy[i] && (na > 0 || nb > 0)) begin
          ew  = 1'b1;
          sel = (na > 0 && nb > 0) ? prio[i] : (nb > 0);
        end
      end else if (phase[i] == 1) begin
        phase[i] = 2;
      end else if (c_rdy[i]) begin
        on = mown[i] ? nb : na;
        if (i == 0 && mlast[i] != 8'h0A && on > 0) begin
          ew  = 1'b1;
          sel = mown[i];
        end else begin
          prio[i]  = !mown[i];
          phase[i] = 0;
        end
      end
      if (ew) begin
        b        = mq[2*i + int'(sel)].pop_front();
        mown[i]  = sel;
        mlast[i] = b;
        phase[i] = 1;
        lg[i].push_back(b);
        lgo[i].push_back(sel);
        lgc[i].push_back(cyc);
      end
      if (c_awe) begin
        if (na == DEPTH) movfa[i] = 1'b1;
        else mq[2*i].push_back(c_ad);
      end
      if (c_bwe) begin
        if (nb == DEPTH) movfb[i] = 1'b1;
        else mq[2*i+1].push_back(c_bd);
      end
    end
    chk($sformatf("tx_we%0d", i),   tx_we[i],   ew);
    chk($sformatf("tx_data%0d", i), tx_data[i], mlast[i]);
    chk($sformatf("owner%0d", i),   owner[i],   mown[i]);
    chk($sformatf("a_full%0d", i),  a_full[i],  mq[2*i].size() == DEPTH);
    chk($sformatf("b_full%0d", i),  b_full[i],  mq[2*i+1].size() == DEPTH);
    chk($sformatf("ovf_a%0d", i),   ovf_a[i],   movfa[i]);
    chk($sformatf("ovf_b%0d", i),   ovf_b[i],   movfb[i]);
  endtask

  // monitor: capture pre-edge inputs, then compare just after the edge
  initial begin
    forever begin
      @(posedge CLK);
      c_rst = RST_X; c_awe = a_we; c_ad = a_d; c_bwe = b_we; c_bd = b_d; c_rdy = rdy;
      cyc++;
      #1;
      step(0);
      step(1);
    end
  end

  // transmitter models: busy for 1..4 cycles after each sampled strobe
  initial begin
    int tc [2];
    tc[0] = 0;
    tc[1] = 0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (tx_we[i]) begin
          rdy[i] = 1'b0;
          tc[i]  = $urandom_range(1, 4);
        end else begin
          if (tc[i] > 0) tc[i]--;
          rdy[i] = (tc[i] == 0) && !hold_low;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input bit wa, input logic [7:0] da, input bit wb, input logic [7:0] db);
    @(negedge CLK);
    a_we = wa; a_d = da; b_we = wb; b_d = db;
  endtask

  task automatic idle();
    @(negedge CLK);
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while (n < lim && !(mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 &&
                        mq[3].size() == 0 && phase[0] == 0 && phase[1] == 0 && rdy == 2'b11)) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, n < lim, 1'b1);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      lg[i].delete();
      lgo[i].delete();
      lgc[i].delete();
    end
  endtask

  task automatic chk_seq(input string tag, input int i,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_len"}, lg[i].size(), 4);
    for (int j = 0; j < 4 && j < lg[i].size(); j++)
      chk($sformatf("%s_%0d", tag, j), lg[i][j], e[j]);
  endtask

  function automatic logic [7:0] rbyte();
    return ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
  endfunction

  initial begin
    int pe;
    repeat (3) @(negedge CLK);
    chk("rst_a_full", a_full, 2'b00);
    chk("rst_tx_we", tx_we, 2'b00);
    chk("rst_tx_data", tx_data[0], 8'h00);
    RST_X = 1'b1;
    drain("drain_rst", 50);

    // round-robin with both requesters loaded at once
    clear_logs();
    push(1'b1, 8'h31, 1'b1, 8'h61);
    push(1'b1, 8'h32, 1'b1, 8'h62);
    idle();
    drain("drain_rr", 100);
    chk_seq("rr_lock", 0, 8'h31, 8'h32, 8'h61, 8'h62);
    chk_seq("rr_free", 1, 8'h31, 8'h61, 8'h32, 8'h62);

    // line lock held until line feed
    clear_logs();
    push(1'b1, 8'h78, 1'b1, 8'h7A);
    push(1'b1, 8'h0A, 1'b0, 8'h00);
    push(1'b1, 8'h79, 1'b0, 8'h00);
    idle();
    drain("drain_lock", 100);
    chk_seq("lock_lock", 0, 8'h78, 8'h0A, 8'h7A, 8'h79);
    chk_seq("lock_free", 1, 8'h78, 8'h7A, 8'h0A, 8'h79);

    // single byte latency
    clear_logs();
    push(1'b1, 8'h41, 1'b0, 8'h00);
    @(posedge CLK);
    #1 pe = cyc;
    idle();
    drain("drain_single", 50);
    chk("single_cnt", lg[0].size(), 1);
    if (lg[0].size() > 0) begin
      chk("single_data", lg[0][0], 8'h41);
      chk("single_owner", lgo[0][0], 1'b0);
      chk("single_latency", lgc[0][0] - pe, 1);
    end

    // overflow with the transmitter stalled
    hold_low = 1'b1;
    repeat (2) @(negedge CLK);
    clear_logs();
    for (int j = 0; j < 5; j++) begin
      push(1'b1, 8'hA0 + 8'(j), 1'b0, 8'h00);
      @(posedge CLK);
      #1;
      if (j == 3) begin
        chk("ovf_full4", a_full[0], 1'b1);
        chk("ovf_flag4", ovf_a[0], 1'b0);
      end
    end
    chk("ovf_full5", a_full[0], 1'b1);
    chk("ovf_flag5", ovf_a, 2'b11);
    idle();
    hold_low = 1'b0;
    drain("drain_ovf", 100);
    chk_seq("ovf_lock", 0, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    chk_seq("ovf_free", 1, 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // reset while waiting on the transmitter with bytes queued
    push(1'b1, 8'hC0, 1'b0, 8'h00);
    push(1'b1, 8'hC1, 1'b0, 8'h00);
    push(1'b1, 8'hC2, 1'b0, 8'h00);
    hold_low = 1'b1;
    push(1'b1, 8'hC3, 1'b0, 8'h00);
    push(1'b1, 8'hC4, 1'b0, 8'h00);
    idle();
    #1 chk("mid_full_before", a_full, 2'b11);
    #1 RST_X = 1'b0;
    #1;
    chk("mid_full_after", a_full, 2'b00);
    chk("mid_tx_we", tx_we, 2'b00);
    chk("mid_tx_data", tx_data[0], 8'h00);
    chk("mid_owner", owner, 2'b00);
    clear_logs();
    @(negedge CLK);
    RST_X = 1'b1;
    hold_low = 1'b0;
    repeat (20) @(negedge CLK);
    chk("mid_no_issue0", lg[0].size(), 0);
    chk("mid_no_issue1", lg[1].size(), 0);

    // random traffic, light then heavy, with occasional resets
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      RST_X = ($urandom_range(0, 499) != 0);
      a_we  = (t < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      b_we  = (t < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a_d   = rbyte();
      b_d   = rbyte();
    end
    idle();
    RST_X = 1'b1;
    drain("drain_final", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
